// File: rtl/sine_stream_analyzer.sv
// ----------------------------------------------------------------------------
// sine_stream_analyzer
//
// Receive-side monitor for a 10-bit offset-binary sine sample stream. Tracks
// the waveform quadrant, measures the period in valid samples between upward
// midpoint crossings, captures per-cycle peak/trough and flags lock once the
// period has repeated LOCK_COUNT times in a row.
//
// Ports:
//   clk          : clock, all logic on rising edge
//   rst_n        : asynchronous active-low reset
//   in_valid     : in_sample carries a valid sample this cycle
//   in_sample    : unsigned offset-binary sample
//   quadrant     : 0=POS_RISE 1=POS_FALL 2=NEG_FALL 3=NEG_RISE (0 while idle)
//   period       : last measured period in valid samples
//   period_valid : one-cycle pulse when period updates
//   peak         : max sample of the last positive half
//   trough       : min sample of the last negative half
//   locked       : period stable
//   error        : one-cycle pulse on mismatch while locked, or on timeout
// ----------------------------------------------------------------------------
module sine_stream_analyzer #(
    parameter int DATA_WIDTH   = 10,
    parameter int MIDPOINT     = 512,
    parameter int HYST         = 4,
    parameter int PERIOD_WIDTH = 12,
    parameter int LOCK_COUNT   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [DATA_WIDTH-1:0]   in_sample,
    output logic [1:0]              quadrant,
    output logic [PERIOD_WIDTH-1:0] period,
    output logic                    period_valid,
    output logic [DATA_WIDTH-1:0]   peak,
    output logic [DATA_WIDTH-1:0]   trough,
    output logic                    locked,
    output logic                    error
);

    // Thresholds carried one bit wider than the sample so MIDPOINT+HYST never wraps.
    localparam logic [DATA_WIDTH:0] HI_TH = (DATA_WIDTH+1)'(MIDPOINT + HYST);
    localparam logic [DATA_WIDTH:0] LO_TH =
        (MIDPOINT > HYST) ? (DATA_WIDTH+1)'(MIDPOINT - HYST) : '0;

    localparam int MW = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
    localparam logic [MW-1:0] LOCK_M = MW'(LOCK_COUNT);

    // Last count value before saturation; the next increment is the timeout.
    localparam logic [PERIOD_WIDTH-1:0] CNT_LAST = {{(PERIOD_WIDTH-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POS_RISE,
        ST_POS_FALL,
        ST_NEG_FALL,
        ST_NEG_RISE
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   prev_q, prev_d;
    logic [DATA_WIDTH-1:0]   run_min_q, run_min_d;
    logic [DATA_WIDTH-1:0]   run_max_q, run_max_d;
    logic [PERIOD_WIDTH-1:0] count_q, count_d;
    logic                    started_q, started_d;
    logic [MW-1:0]           match_q, match_d;
    logic [PERIOD_WIDTH-1:0] period_q, period_d;
    logic                    period_valid_q, period_valid_d;
    logic [DATA_WIDTH-1:0]   peak_q, peak_d;
    logic [DATA_WIDTH-1:0]   trough_q, trough_d;
    logic                    locked_q, locked_d;
    logic                    error_q, error_d;
    logic                    crossing;
    logic [DATA_WIDTH:0]     s_ext;

    assign s_ext = {1'b0, in_sample};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            prev_q         <= '0;
            run_min_q      <= '1;
            run_max_q      <= '0;
            count_q        <= '0;
            started_q      <= 1'b0;
            match_q        <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            peak_q         <= '0;
            trough_q       <= '1;
            locked_q       <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            prev_q         <= prev_d;
            run_min_q      <= run_min_d;
            run_max_q      <= run_max_d;
            count_q        <= count_d;
            started_q      <= started_d;
            match_q        <= match_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            peak_q         <= peak_d;
            trough_q       <= trough_d;
            locked_q       <= locked_d;
            error_q        <= error_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        prev_d         = prev_q;
        run_min_d      = run_min_q;
        run_max_d      = run_max_q;
        count_d        = count_q;
        started_d      = started_q;
        match_d        = match_q;
        period_d       = period_q;
        period_valid_d = 1'b0;
        peak_d         = peak_q;
        trough_d       = trough_q;
        locked_d       = locked_q;
        error_d        = 1'b0;
        crossing       = 1'b0;

        if (in_valid) begin
            prev_d = in_sample;

            // Direction tests are strict, so a repeated sample never turns the FSM.
            case (state_q)
                ST_IDLE: begin
                    if (s_ext < LO_TH) begin
                        state_d   = ST_NEG_FALL;
                        run_min_d = in_sample;
                    end
                end
                ST_NEG_FALL: begin
                    if (in_sample > prev_q) begin
                        state_d  = ST_NEG_RISE;
                        trough_d = run_min_q;
                    end else if (in_sample < run_min_q) begin
                        run_min_d = in_sample;
                    end
                end
                ST_NEG_RISE: begin
                    if (s_ext >= HI_TH) begin
                        state_d   = ST_POS_RISE;
                        run_max_d = in_sample;
                        crossing  = 1'b1;
                    end
                end
                ST_POS_RISE: begin
                    if (in_sample < prev_q) begin
                        state_d = ST_POS_FALL;
                        peak_d  = run_max_q;
                    end else if (in_sample > run_max_q) begin
                        run_max_d = in_sample;
                    end
                end
                ST_POS_FALL: begin
                    if (s_ext <= LO_TH) begin
                        state_d   = ST_NEG_FALL;
                        run_min_d = in_sample;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (crossing) begin
                // The crossing sample is sample 1 of the new period.
                count_d   = {{(PERIOD_WIDTH-1){1'b0}}, 1'b1};
                started_d = 1'b1;
                if (started_q) begin
                    period_d       = count_q;
                    period_valid_d = 1'b1;
                    if (count_q == period_q) begin
                        if (match_q != LOCK_M) begin
                            match_d = match_q + 1'b1;
                        end
                    end else begin
                        match_d = '0;
                        if (locked_q) begin
                            error_d = 1'b1;
                        end
                    end
                    locked_d = (match_d >= LOCK_M);
                end
            end else if (started_q) begin
                if (count_q == CNT_LAST) begin
                    // Timeout: abandon the measurement, keep the last period.
                    error_d   = 1'b1;
                    locked_d  = 1'b0;
                    state_d   = ST_IDLE;
                    count_d   = '0;
                    started_d = 1'b0;
                    match_d   = '0;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        quadrant = 2'd0;
        case (state_q)
            ST_POS_RISE: quadrant = 2'd0;
            ST_POS_FALL: quadrant = 2'd1;
            ST_NEG_FALL: quadrant = 2'd2;
            ST_NEG_RISE: quadrant = 2'd3;
            default:     quadrant = 2'd0;
        endcase
    end

    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign peak         = peak_q;
    assign trough       = trough_q;
    assign locked       = locked_q;
    assign error        = error_q;

endmodule
